// File: rtl/input_conditioner.sv
// Input conditioner: two-flop synchronizers plus stability debounce for three switch levels and an N-bit current code.
// Build option INPUT_CONDITIONER_PULSES_EN adds temp_sube/humo_sube/cor_cambio pulses; otherwise those ports read 0.
module input_conditioner #(
  parameter int N         = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         interruptor_raw,
  input  logic         temp_raw,
  input  logic         humo_raw,
  input  logic [N-1:0] corriente_raw,
  output logic         interruptor,
  output logic         temp,
  output logic         humo,
  output logic [N-1:0] corriente,
  output logic         temp_sube,
  output logic         humo_sube,
  output logic         cor_cambio
);

  localparam logic [15:0] CNT_LAST = 16'(DB_CYCLES - 1);

  logic [2:0] bit_raw;
  logic [2:0] bit_q;
`ifdef INPUT_CONDITIONER_PULSES_EN
  logic [2:1] bit_rise;
`endif

  assign bit_raw = {humo_raw, temp_raw, interruptor_raw};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_bit
      logic        s1_reg;
      logic        s2_reg;
      logic        q_reg;
      logic [15:0] cnt_reg;
      logic        load;

      assign load = (s2_reg != q_reg) && (cnt_reg == CNT_LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          q_reg   <= 1'b0;
          cnt_reg <= '0;
        end else begin
          s1_reg <= bit_raw[gi];
          s2_reg <= s1_reg;
          if (load) begin
            q_reg   <= s2_reg;
            cnt_reg <= '0;
          end else if (s2_reg == q_reg) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
      end

      assign bit_q[gi] = q_reg;

`ifdef INPUT_CONDITIONER_PULSES_EN
      // interruptor (bit 0) has no edge pulse
      if (gi > 0) begin : g_rise
        assign bit_rise[gi] = load & s2_reg;
      end
`endif
    end
  endgenerate

  assign interruptor = bit_q[0];
  assign temp        = bit_q[1];
  assign humo        = bit_q[2];

  // Vector channel: cand lags s2 by one edge, so any bit change mid-count restarts it
  logic [N-1:0] c_s1_reg;
  logic [N-1:0] c_s2_reg;
  logic [N-1:0] cand_reg;
  logic [N-1:0] cor_reg;
  logic [15:0]  c_cnt_reg;
  logic         cor_load;

  assign cor_load = (c_s2_reg == cand_reg) && (c_s2_reg != cor_reg) && (c_cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_s1_reg  <= '0;
      c_s2_reg  <= '0;
      cand_reg  <= '0;
      cor_reg   <= '0;
      c_cnt_reg <= '0;
    end else begin
      c_s1_reg <= corriente_raw;
      c_s2_reg <= c_s1_reg;
      cand_reg <= c_s2_reg;
      if (cor_load) begin
        cor_reg   <= c_s2_reg;
        c_cnt_reg <= '0;
      end else if ((c_s2_reg != cand_reg) || (c_s2_reg == cor_reg)) begin
        c_cnt_reg <= '0;
      end else begin
        c_cnt_reg <= c_cnt_reg + 16'd1;
      end
    end
  end

  assign corriente = cor_reg;

`ifdef INPUT_CONDITIONER_PULSES_EN
  logic temp_sube_reg;
  logic humo_sube_reg;
  logic cor_cambio_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      temp_sube_reg  <= 1'b0;
      humo_sube_reg  <= 1'b0;
      cor_cambio_reg <= 1'b0;
    end else begin
      temp_sube_reg  <= bit_rise[1];
      humo_sube_reg  <= bit_rise[2];
      cor_cambio_reg <= cor_load;
    end
  end

  assign temp_sube  = temp_sube_reg;
  assign humo_sube  = humo_sube_reg;
  assign cor_cambio = cor_cambio_reg;
`else
  assign temp_sube  = 1'b0;
  assign humo_sube  = 1'b0;
  assign cor_cambio = 1'b0;
`endif

endmodule
